sram_1r1w_init: RTL and testbench
=================================

// Module: sram_1r1w_init
// PURPOSE
// - Synthesizable single-clock 1-write/1-read SRAM model for L2 tag/data arrays.
// - Generalised in width/depth; adds per-bit write mask, registered read with valid flag,
//   a post-reset clear sequencer and same-address read/write collision handling.
// - Sits between the L2 controller and the array storage; `ready` gates all controller traffic.
// PARAMETERS
// - DATA_WIDTH  17  bits per word
// - ADDR_WIDTH  7   address bits
// - RAM_DEPTH   1<<ADDR_WIDTH  number of words; must be <= 2**ADDR_WIDTH
// - INIT_VALUE  {DATA_WIDTH{1'b0}}  value written to every word by the clear sequencer
// PORTS
// - clk     in   1           rising-edge clock
// - rst     in   1           synchronous active-high reset
// - we      in   1           write enable
// - waddr   in   ADDR_WIDTH  write address
// - wdata   in   DATA_WIDTH  write data
// - wmask   in   DATA_WIDTH  per-bit write mask; 1 = bit updated
// - re      in   1           read enable
// - raddr   in   ADDR_WIDTH  read address
// - rdata   out  DATA_WIDTH  read data, registered
// - rvalid  out  1           rdata valid; exactly 1 cycle after an accepted read
// - ready   out  1           1 = array initialised; we/re are accepted
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=INIT, clear pointer=0, rdata=0, rvalid=0, ready=0.
// - FSM: INIT -> RUN once pointer == RAM_DEPTH-1 has been written; RUN -> INIT only on rst.
// - INIT: write INIT_VALUE to mem[pointer] each cycle, pointer++. Clearing takes RAM_DEPTH
//   cycles after rst deasserts; ready rises on the cycle after the last clear write.
//   we/re are ignored in INIT: no memory update, rvalid stays 0.
// - rst mid-INIT or mid-RUN: pointer returns to 0 and the clear restarts in full;
//   a read pending in the pipeline is dropped (rvalid=0 next cycle).
// - Write (RUN, we=1): mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask) at posedge;
//   wmask=0 is a legal no-op write.
// - Read (RUN, re=1): rdata <= mem[raddr], rvalid <= 1 at the same posedge; latency 1 cycle.
//   re=0: rvalid <= 0 and rdata holds its previous value.
// - Addresses >= RAM_DEPTH: write dropped; read returns INIT_VALUE with rvalid=1.
// - Simultaneous we and re, different addresses: both complete independently.
// - Simultaneous we and re, same address: behaviour set by SRAM_FWD_EN (CONFIGURATION).
// - No back-pressure in RUN: one read and one write per cycle, every cycle.
// CONFIGURATION
// - Macro SRAM_FWD_EN defined: write-first. A same-address collision returns the merged word
//   (old & ~wmask) | (wdata & wmask) in rdata.
// - SRAM_FWD_EN undefined: read-first. A collision returns the pre-write word; the write
//   still lands and is visible to the next read.
// - No simulation warnings or $display in either build.
// TESTING
// - Reset then idle: ready=0 for 128 cycles after rst deasserts, then ready=1.
//   Every address reads 17'h0 with rvalid=1 one cycle after re.
// - RUN: write addr 5 = 17'h1ABCD with full mask, then read addr 5 -> next cycle rdata=17'h1ABCD,
//   rvalid=1. The cycle after, with re=0: rvalid=0 and rdata still 17'h1ABCD.
// - Masked write: addr 9 = 17'h1FFFF, then wdata=17'h00000, wmask=17'h000FF
//   -> read addr 9 returns 17'h1FF00.
// - Collision: addr 3 holds 17'h00011; write 17'h00022 (full mask) and read addr 3 in the same
//   cycle -> rdata=17'h00022 with SRAM_FWD_EN, 17'h00011 without it.
//   A second read of addr 3 returns 17'h00022 in both builds.
// - rst asserted at clear pointer 60 -> ready stays 0 for a full 128 further cycles.
//   addr 100, written in the previous RUN, reads 17'h0.
// - we/re asserted during INIT (addr 7, 17'h1) -> rvalid stays 0; after ready, addr 7 reads 17'h0.

Source files
------------

// File: rtl/sram_1r1w_init.sv
// 1-write/1-read SRAM with per-bit write mask, registered read and post-reset clear sequencer.
// Define SRAM_FWD_EN for write-first collisions; the default build is read-first.
module sram_1r1w_init #(
    parameter int                    DATA_WIDTH = 17,
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] wmask,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  ready
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] merged;
    logic                  waddr_in, raddr_in, wr_ok, rd_ok;

    assign ready    = (state == RUN);
    assign waddr_in = {1'b0, waddr} < DEPTH_EXT;
    assign raddr_in = {1'b0, raddr} < DEPTH_EXT;
    assign wr_ok    = ready && we && waddr_in;
    assign rd_ok    = ready && re;
    assign merged   = (mem[waddr] & ~wmask) | (wdata & wmask);

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (ptr == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) ptr <= ptr + 1'b1;
        end
    end

    // Storage has no reset of its own; the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[ptr] <= INIT_VALUE;
            else if (wr_ok)
                mem[waddr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            if (rd_ok) begin
                if (!raddr_in)
                    rdata <= INIT_VALUE;
`ifdef SRAM_FWD_EN
                else if (wr_ok && (waddr == raddr))
                    rdata <= merged;
`endif
                else
                    rdata <= mem[raddr];
            end
        end
    end
endmodule

// File: tb/tb_sram_1r1w_init.sv
// Scoreboard bench for sram_1r1w_init: reference array model, randomized traffic, reset/clear timing.
module tb_sram_1r1w_init;
    localparam int DW = 17;
    localparam int AW = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst, we, re;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata, wmask, rdata;
    logic          rvalid, ready;

    int nerr = 0;
    int nchk = 0;

    logic [DW-1:0] model [DEPTH];
    logic          model_run = 1'b0;
    logic [DW-1:0] exp_q [$];

    sram_1r1w_init dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .ready(ready)
    );

    always #5 clk = ~clk;

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            nchk++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h, required no read outstanding", rdata);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    nerr++;
                    $display("FAIL read_data: got %h, required %h", rdata, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Drives one clock cycle from a negedge; returns at the next negedge.
    task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [DW-1:0] wm, input logic r, input logic [AW-1:0] ra);
        logic [DW-1:0] e;
        we = w; waddr = wa; wdata = wd; wmask = wm; re = r; raddr = ra;
        if (model_run && r) begin
            e = model[ra];
`ifdef SRAM_FWD_EN
            if (w && wa == ra) e = (model[wa] & ~wm) | (wd & wm);
`endif
            exp_q.push_back(e);
        end
        if (model_run && w) model[wa] = (model[wa] & ~wm) | (wd & wm);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Reset (optionally with a read held during rst), optionally abort the clear after
    // abort_at INIT cycles of ignored traffic, then measure the clear duration.
    task automatic do_reset(input logic re_in_rst, input int abort_at);
        int cnt;
        model_run = 1'b0;
        rst = 1'b1;
        cyc(1'b0, '0, '0, '0, re_in_rst, 7'd0);
        check("rvalid_in_reset", {16'b0, rvalid}, '0);
        cyc(1'b0, '0, '0, '0, re_in_rst, 7'd0);
        check("rdata_after_reset", rdata, '0);
        check("ready_after_reset", {16'b0, ready}, '0);
        rst = 1'b0;
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) begin
                cyc(1'b1, 7'd7, 17'h1, '1, 1'b1, 7'd7);
                if (rvalid !== 1'b0 || ready !== 1'b0) begin
                    nchk++; nerr++;
                    $display("FAIL init_ignore: got rvalid=%b ready=%b, required 0/0", rvalid, ready);
                end
            end
            nchk++;
            rst = 1'b1;
            idle();
            rst = 1'b0;
        end
        cnt = 0;
        while (ready !== 1'b1 && cnt < 400) begin
            idle();
            cnt++;
        end
        check("clear_cycles", DW'(cnt), DW'(128));
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model_run = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a, b;
        rst = 1'b0; we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; wdata = '0; wmask = '0;
        @(negedge clk);
        do_reset(1'b0, 0);

        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, '0, '0, 1'b1, AW'(i));

        cyc(1'b1, 7'd5, 17'h1ABCD, '1, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 7'd5);
        check("read5_rvalid", {16'b0, rvalid}, 17'h1);
        idle();
        check("hold_rvalid", {16'b0, rvalid}, '0);
        check("hold_rdata", rdata, 17'h1ABCD);

        cyc(1'b1, 7'd9, 17'h1FFFF, '1, 1'b0, '0);
        cyc(1'b1, 7'd9, 17'h00000, 17'h000FF, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 7'd9);
        check("masked9", rdata, 17'h1FF00);

        cyc(1'b1, 7'd3, 17'h00011, '1, 1'b0, '0);
        cyc(1'b1, 7'd3, 17'h00022, '1, 1'b1, 7'd3);
`ifdef SRAM_FWD_EN
        check("collision3", rdata, 17'h00022);
`else
        check("collision3", rdata, 17'h00011);
`endif
        cyc(1'b0, '0, '0, '0, 1'b1, 7'd3);
        check("after_collision3", rdata, 17'h00022);

        cyc(1'b1, 7'd10, 17'h1234, '1, 1'b1, 7'd5);
        cyc(1'b0, '0, '0, '0, 1'b1, 7'd10);

        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : AW'($urandom);
            cyc(1'($urandom), a, DW'($urandom), ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom),
                1'($urandom), b);
        end

        cyc(1'b1, 7'd100, 17'h15555, '1, 1'b0, '0);
        do_reset(1'b1, 60);
        cyc(1'b0, '0, '0, '0, 1'b1, 7'd100);
        check("addr100_cleared", rdata, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 7'd7);
        check("addr7_cleared", rdata, '0);

        idle(); idle();
        check("scoreboard_drained", DW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
